// File: rtl/spartan_isa_pkg.sv
// Shared Spartan ISA definitions: opcode encodings, sequencer states,
// decoded-instruction and strobe payloads.
package spartan_isa_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_W   = 4;

  // 3-operand opcodes, instr[15:12]
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OPC_W-1:0] OP_MUL  = 4'h3;
  localparam logic [OPC_W-1:0] OP_DIV  = 4'h4;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h5;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h6;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'h7;
  localparam logic [OPC_W-1:0] OP_SHR  = 4'h8;
  localparam logic [OPC_W-1:0] OP_SHL  = 4'h9;
  localparam logic [OPC_W-1:0] OP_LDU  = 4'hA;
  localparam logic [OPC_W-1:0] OP_LDL  = 4'hB;
  localparam logic [OPC_W-1:0] OP_PFX2 = 4'hF;

  // 2-operand opcodes, instr[11:8] under OP_PFX2
  localparam logic [OPC_W-1:0] OP2_STI  = 4'h0;
  localparam logic [OPC_W-1:0] OP2_DLD  = 4'h1;
  localparam logic [OPC_W-1:0] OP2_CAL  = 4'h2;
  localparam logic [OPC_W-1:0] OP2_JMP  = 4'h3;
  localparam logic [OPC_W-1:0] OP2_PFX1 = 4'hF;

  // 1-operand prefix instr[7:4], 0-operand opcodes instr[3:0]
  localparam logic [OPC_W-1:0] OP1_PFX0 = 4'hF;
  localparam logic [OPC_W-1:0] OP0_RIT  = 4'h1;
  localparam logic [OPC_W-1:0] OP0_NOP  = 4'hF;

  localparam int unsigned FLAG_EQ = 0;
  localparam int unsigned FLAG_GT = 1;

  typedef enum logic [3:0] {
    ST_FLUSH, ST_FETCH, ST_DECODE, ST_WB_UPPER, ST_WB_LOWER,
    ST_WB_ALU, ST_WB_ALU2, ST_WB_MEM, ST_IRQ_ENTRY, ST_HALT
  } state_t;

  typedef enum logic [3:0] {
    CLS_ILL, CLS_ALU, CLS_LDU, CLS_LDL, CLS_JMP,
    CLS_STI, CLS_DLD, CLS_CAL, CLS_RIT, CLS_NOP
  } cls_t;

  typedef struct packed {
    cls_t             cls;
    logic [OPC_W-1:0] op;
    logic [3:0]       f_hi;   // instr[11:8]
    logic [3:0]       f_mid;  // instr[7:4]
    logic [3:0]       f_lo;   // instr[3:0]
  } dec_t;

  typedef struct packed {
    logic i_req;
    logic irq_ack;
    logic pc_inc;
    logic pc_load;
    logic pc_push;
    logic ret_save;
    logic ret_restore;
    logic reg3_we_u;
    logic reg3_we_l;
    logic reg4_we;
    logic lu_push;
    logic lu_push_high;
    logic d_read;
    logic d_write;
    logic d_push;
    logic imm_oe;
  } strobe_t;

endpackage

// File: rtl/isa_decoder.sv
// Combinational field split and legality/class decode of one instruction word.
module isa_decoder
  import spartan_isa_pkg::*;
#(
  parameter bit IRQ_EN = 1'b1
) (
  input  logic [INSTR_W-1:0] instr,
  output dec_t               dec_c
);

  always_comb begin
    dec_c.op    = instr[15:12];
    dec_c.f_hi  = instr[11:8];
    dec_c.f_mid = instr[7:4];
    dec_c.f_lo  = instr[3:0];
    dec_c.cls   = CLS_ILL;
    if (instr[15:12] >= OP_ADD && instr[15:12] <= OP_SHL) begin
      dec_c.cls = CLS_ALU;
    end else if (instr[15:12] == OP_LDU) begin
      dec_c.cls = CLS_LDU;
    end else if (instr[15:12] == OP_LDL) begin
      dec_c.cls = CLS_LDL;
    end else if (instr[15:12] == OP_PFX2) begin
      case (instr[11:8])
        OP2_STI: dec_c.cls = CLS_STI;
        OP2_DLD: dec_c.cls = CLS_DLD;
        OP2_CAL: dec_c.cls = CLS_CAL;
        OP2_JMP: dec_c.cls = CLS_JMP;
        OP2_PFX1: begin
          // rit only exists when interrupt entry is built in
          if (instr[7:4] == OP1_PFX0) begin
            if (instr[3:0] == OP0_NOP)               dec_c.cls = CLS_NOP;
            else if (instr[3:0] == OP0_RIT && IRQ_EN) dec_c.cls = CLS_RIT;
          end
        end
        default: dec_c.cls = CLS_ILL;
      endcase
    end
  end

endmodule

// File: rtl/seq_control_unit.sv
// Spartan multi-cycle sequencer: fetch handshake, decode, write-back strobes,
// interrupt entry/return and sticky illegal-opcode halt.
module seq_control_unit
  import spartan_isa_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4,
  parameter bit          IRQ_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              i_req,
  input  logic              i_ack,
  input  logic [15:0]       i_data,
  input  logic [DATA_W-1:0] flags,
  input  logic              irq,
  output logic              irq_ack,
  output logic              pc_inc,
  output logic              pc_load,
  output logic              pc_push,
  output logic              ret_save,
  output logic              ret_restore,
  output logic [REG_AW-1:0] reg1_addr,
  output logic [REG_AW-1:0] reg2_addr,
  output logic [REG_AW-1:0] reg3_addr,
  output logic [REG_AW-1:0] reg4_addr,
  output logic              reg3_we_u,
  output logic              reg3_we_l,
  output logic              reg4_we,
  output logic [3:0]        lu_op,
  output logic              lu_push,
  output logic              lu_push_high,
  output logic              d_read,
  output logic              d_write,
  output logic              d_push,
  output logic [DATA_W-1:0] imm,
  output logic              imm_oe,
  output logic              irq_masked,
  output logic              halted,
  output logic              illegal
);

  state_t            state, state_n;
  strobe_t           strb, strb_c;
  logic [15:0]       ir, ir_n;
  logic [REG_AW-1:0] reg1_n, reg2_n, reg3_n, reg4_n;
  logic [3:0]        lu_op_n;
  logic [DATA_W-1:0] imm_n;
  logic              mask_n, halted_n, illegal_n;
  dec_t              dec_c;
  logic              jmp_take_c;
  logic              unused_flags_c;

  isa_decoder #(.IRQ_EN(IRQ_EN)) u_dec (.instr(ir), .dec_c(dec_c));

  // condition bits instr[6:4] select eq / not-greater / greater
  assign jmp_take_c = (dec_c.f_mid[0] &  flags[FLAG_EQ])
                    | (dec_c.f_mid[1] & ~flags[FLAG_GT])
                    | (dec_c.f_mid[2] &  flags[FLAG_GT]);
  assign unused_flags_c = ^flags[DATA_W-1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FLUSH;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    strb_c    = '0;
    ir_n      = ir;
    reg1_n    = reg1_addr;
    reg2_n    = reg2_addr;
    reg3_n    = reg3_addr;
    reg4_n    = reg4_addr;
    lu_op_n   = lu_op;
    imm_n     = imm;
    mask_n    = irq_masked;
    halted_n  = halted;
    illegal_n = illegal;
    case (state)
      ST_FLUSH: state_n = ST_FETCH;
      ST_FETCH: begin
        if (i_ack && strb.i_req) begin
          ir_n          = i_data;
          strb_c.pc_inc = 1'b1;
          state_n       = ST_DECODE;
        end
      end
      ST_DECODE: begin
        lu_op_n = '0;
        case (dec_c.cls)
          CLS_ALU: begin
            reg1_n  = REG_AW'(dec_c.f_mid);
            reg2_n  = REG_AW'(dec_c.f_lo);
            reg3_n  = REG_AW'(dec_c.f_hi);
            lu_op_n = dec_c.op;
            state_n = ST_WB_ALU;
          end
          CLS_LDU: begin
            reg3_n  = REG_AW'(dec_c.f_hi);
            imm_n   = {dec_c.f_mid, dec_c.f_lo, {(DATA_W-8){1'b0}}};
            state_n = ST_WB_UPPER;
          end
          CLS_LDL: begin
            reg3_n  = REG_AW'(dec_c.f_hi);
            imm_n   = DATA_W'({dec_c.f_mid, dec_c.f_lo});
            state_n = ST_WB_LOWER;
          end
          CLS_JMP: begin
            reg1_n         = REG_AW'(dec_c.f_lo);
            strb_c.pc_load = jmp_take_c;
            state_n        = ST_FLUSH;
          end
          CLS_STI: begin
            reg1_n         = REG_AW'(dec_c.f_mid);
            reg2_n         = REG_AW'(dec_c.f_lo);
            reg4_n         = REG_AW'(dec_c.f_lo);
            strb_c.d_write = 1'b1;
            state_n        = ST_WB_ALU2;
          end
          CLS_DLD: begin
            // pointer is pre-decremented, then the read addresses through reg2
            reg2_n         = REG_AW'(dec_c.f_mid);
            reg4_n         = REG_AW'(dec_c.f_mid);
            reg3_n         = REG_AW'(dec_c.f_lo);
            strb_c.reg4_we = 1'b1;
            state_n        = ST_WB_MEM;
          end
          CLS_CAL: begin
            reg1_n           = REG_AW'(dec_c.f_mid);
            reg3_n           = REG_AW'(dec_c.f_lo);
            strb_c.pc_push   = 1'b1;
            strb_c.reg3_we_u = 1'b1;
            strb_c.reg3_we_l = 1'b1;
            strb_c.pc_load   = 1'b1;
            state_n          = ST_FLUSH;
          end
          CLS_RIT: begin
            strb_c.ret_restore = 1'b1;
            mask_n             = 1'b0;
            state_n            = ST_FLUSH;
          end
          CLS_NOP: state_n = ST_FETCH;
          default: begin
            illegal_n = 1'b1;
            halted_n  = 1'b1;
            state_n   = ST_HALT;
          end
        endcase
      end
      ST_WB_UPPER: begin
        strb_c.imm_oe    = 1'b1;
        strb_c.reg3_we_u = 1'b1;
        state_n          = ST_FETCH;
      end
      ST_WB_LOWER: begin
        strb_c.imm_oe    = 1'b1;
        strb_c.reg3_we_l = 1'b1;
        state_n          = ST_FETCH;
      end
      ST_WB_ALU: begin
        strb_c.lu_push   = 1'b1;
        strb_c.reg3_we_u = 1'b1;
        strb_c.reg3_we_l = 1'b1;
        state_n          = ST_FETCH;
      end
      ST_WB_ALU2: begin
        strb_c.reg4_we = 1'b1;
        state_n        = ST_FETCH;
      end
      ST_WB_MEM: begin
        strb_c.d_read    = 1'b1;
        strb_c.d_push    = 1'b1;
        strb_c.reg3_we_u = 1'b1;
        strb_c.reg3_we_l = 1'b1;
        state_n          = ST_FETCH;
      end
      ST_IRQ_ENTRY: begin
        strb_c.ret_save = 1'b1;
        strb_c.pc_load  = 1'b1;
        strb_c.irq_ack  = IRQ_EN;
        mask_n          = 1'b1;
        state_n         = ST_FLUSH;
      end
      ST_HALT: state_n = ST_HALT;
      default: state_n = ST_FLUSH;
    endcase
    // irq is only sampled on the way into FETCH
    if (state_n == ST_FETCH && state != ST_FETCH && IRQ_EN && irq && !irq_masked)
      state_n = ST_IRQ_ENTRY;
    strb_c.i_req = (state_n == ST_FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strb       <= '0;
      ir         <= '0;
      reg1_addr  <= '0;
      reg2_addr  <= '0;
      reg3_addr  <= '0;
      reg4_addr  <= '0;
      lu_op      <= '0;
      imm        <= '0;
      irq_masked <= 1'b0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      strb       <= strb_c;
      ir         <= ir_n;
      reg1_addr  <= reg1_n;
      reg2_addr  <= reg2_n;
      reg3_addr  <= reg3_n;
      reg4_addr  <= reg4_n;
      lu_op      <= lu_op_n;
      imm        <= imm_n;
      irq_masked <= mask_n;
      halted     <= halted_n;
      illegal    <= illegal_n;
    end
  end

  assign i_req        = strb.i_req;
  assign irq_ack      = strb.irq_ack;
  assign pc_inc       = strb.pc_inc;
  assign pc_load      = strb.pc_load;
  assign pc_push      = strb.pc_push;
  assign ret_save     = strb.ret_save;
  assign ret_restore  = strb.ret_restore;
  assign reg3_we_u    = strb.reg3_we_u;
  assign reg3_we_l    = strb.reg3_we_l;
  assign reg4_we      = strb.reg4_we;
  assign lu_push      = strb.lu_push;
  assign lu_push_high = strb.lu_push_high;
  assign d_read       = strb.d_read;
  assign d_write      = strb.d_write;
  assign d_push       = strb.d_push;
  assign imm_oe       = strb.imm_oe;

endmodule

// File: tb/tb_seq_control_unit.sv
// Bench for seq_control_unit: directed plan steps plus random instruction
// streams checked against a per-instruction timeline model.
module tb_seq_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_ack, irq, irq_ack;
  logic [15:0] i_data, flags;
  logic        pc_inc, pc_load, pc_push, ret_save, ret_restore;
  logic [3:0]  reg1_addr, reg2_addr, reg3_addr, reg4_addr, lu_op;
  logic        reg3_we_u, reg3_we_l, reg4_we, lu_push, lu_push_high;
  logic        d_read, d_write, d_push, imm_oe, irq_masked, halted, illegal;
  logic [15:0] imm;

  int vectors = 0;
  int miscompares = 0;
  bit mask_m = 1'b0;

  localparam int K_ALU = 0, K_LDU = 1, K_LDL = 2, K_JMP = 3, K_STI = 4,
                 K_DLD = 5, K_CAL = 6, K_RIT = 7, K_NOP = 8;
  localparam int B_PCINC = 0, B_PCLOAD = 1, B_PCPUSH = 2, B_RSAVE = 3,
                 B_RREST = 4, B_IRQACK = 5, B_WEU = 6, B_WEL = 7, B_R4WE = 8,
                 B_LUPUSH = 9, B_DREAD = 10, B_DWRITE = 11, B_DPUSH = 12,
                 B_IMMOE = 13, B_LUHIGH = 14;

  always #5 clk = ~clk;

  seq_control_unit dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_ack(i_ack), .i_data(i_data),
    .flags(flags), .irq(irq), .irq_ack(irq_ack), .pc_inc(pc_inc),
    .pc_load(pc_load), .pc_push(pc_push), .ret_save(ret_save),
    .ret_restore(ret_restore), .reg1_addr(reg1_addr), .reg2_addr(reg2_addr),
    .reg3_addr(reg3_addr), .reg4_addr(reg4_addr), .reg3_we_u(reg3_we_u),
    .reg3_we_l(reg3_we_l), .reg4_we(reg4_we), .lu_op(lu_op),
    .lu_push(lu_push), .lu_push_high(lu_push_high), .d_read(d_read),
    .d_write(d_write), .d_push(d_push), .imm(imm), .imm_oe(imm_oe),
    .irq_masked(irq_masked), .halted(halted), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] obs_strb();
    return {lu_push_high, imm_oe, d_push, d_write, d_read, lu_push, reg4_we,
            reg3_we_l, reg3_we_u, irq_ack, ret_restore, ret_save, pc_push,
            pc_load, pc_inc};
  endfunction

  function automatic logic [63:0] all_out();
    return {9'd0, i_req, obs_strb(), reg1_addr, reg2_addr, reg3_addr, reg4_addr,
            lu_op, imm, irq_masked, halted, illegal};
  endfunction

  function automatic logic [15:0] gen(input int kind);
    logic [15:0] r;
    r = 16'($urandom);
    case (kind)
      K_ALU:   return {4'($urandom_range(1, 9)), r[11:0]};
      K_LDU:   return {4'hA, r[11:0]};
      K_LDL:   return {4'hB, r[11:0]};
      K_JMP:   return {8'hF3, r[7:0]};
      K_STI:   return {8'hF0, r[7:0]};
      K_DLD:   return {8'hF1, r[7:0]};
      K_CAL:   return {8'hF2, r[7:0]};
      K_RIT:   return 16'hFFF1;
      default: return 16'hFFFF;
    endcase
  endfunction

  // Expected observable state k cycles after the cycle i_ack was accepted.
  // Write-type instructions re-enter fetch 3 cycles out, nop after 2; a pending
  // unmasked irq at that point adds an entry cycle and a flush.
  task automatic model(input int kind, input logic [15:0] ins, input logic [15:0] fl,
                       input bit irq_l, input bit m0, input int k,
                       output logic [14:0] s, output bit req, output bit msk);
    int e;
    bit take, jt;
    s = '0;
    if (k == 1) s[B_PCINC] = 1'b1;
    jt = (ins[4] && fl[0]) || (ins[5] && !fl[1]) || (ins[6] && fl[1]);
    case (kind)
      K_ALU: if (k == 3) begin s[B_LUPUSH] = 1; s[B_WEU] = 1; s[B_WEL] = 1; end
      K_LDU: if (k == 3) begin s[B_WEU] = 1; s[B_IMMOE] = 1; end
      K_LDL: if (k == 3) begin s[B_WEL] = 1; s[B_IMMOE] = 1; end
      K_JMP: if (k == 2) s[B_PCLOAD] = jt;
      K_STI: begin
        if (k == 2) s[B_DWRITE] = 1;
        if (k == 3) s[B_R4WE] = 1;
      end
      K_DLD: begin
        if (k == 2) s[B_R4WE] = 1;
        if (k == 3) begin s[B_DREAD] = 1; s[B_DPUSH] = 1; s[B_WEU] = 1; s[B_WEL] = 1; end
      end
      K_CAL: if (k == 2) begin s[B_PCPUSH] = 1; s[B_PCLOAD] = 1; s[B_WEU] = 1; s[B_WEL] = 1; end
      K_RIT: if (k == 2) s[B_RREST] = 1;
      default: ;
    endcase
    e = (kind == K_NOP) ? 2 : 3;
    take = irq_l && (kind == K_RIT || !m0);
    msk = m0;
    if (kind == K_RIT && k >= 2) msk = 1'b0;
    if (take && k >= e + 1) msk = 1'b1;
    if (take && k == e + 1) begin s[B_RSAVE] = 1; s[B_PCLOAD] = 1; s[B_IRQACK] = 1; end
    req = take ? (k >= e + 2) : (k >= e);
  endtask

  task automatic check_fields(input int kind, input logic [15:0] ins);
    case (kind)
      K_ALU: chk("alu_fields", {reg1_addr, reg2_addr, reg3_addr, lu_op},
                 {ins[7:4], ins[3:0], ins[11:8], ins[15:12]});
      K_LDU: chk("ldu_fields", {reg3_addr, imm, imm_oe, lu_op},
                 {ins[11:8], ins[7:0], 8'h00, 1'b1, 4'h0});
      K_LDL: chk("ldl_fields", {reg3_addr, imm, imm_oe, lu_op},
                 {ins[11:8], 8'h00, ins[7:0], 1'b1, 4'h0});
      K_JMP: chk("jmp_fields", {reg1_addr, lu_op}, {ins[3:0], 4'h0});
      K_STI: chk("sti_fields", {reg1_addr, reg2_addr, reg4_addr}, {ins[7:4], ins[3:0], ins[3:0]});
      K_DLD: chk("dld_fields", {reg4_addr, reg3_addr}, {ins[7:4], ins[3:0]});
      K_CAL: chk("cal_fields", {reg1_addr, reg3_addr}, {ins[7:4], ins[3:0]});
      default: ;
    endcase
  endtask

  task automatic wait_req();
    int n = 0;
    while (i_req !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req", i_req, 1'b1);
  endtask

  task automatic run(input int kind, input logic [15:0] ins, input logic [15:0] fl, input int stall);
    logic [14:0] es;
    bit er, em;
    wait_req();
    flags = fl;
    repeat (stall) @(negedge clk);
    i_ack  = 1'b1;
    i_data = ins;
    @(negedge clk);
    i_ack  = 1'b0;
    i_data = 16'($urandom);
    em = mask_m;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      model(kind, ins, fl, irq, mask_m, k, es, er, em);
      chk($sformatf("strobes k%0d ins %h", k, ins), obs_strb(), es);
      chk($sformatf("i_req k%0d ins %h", k, ins), i_req, er);
      chk($sformatf("irq_masked k%0d ins %h", k, ins), irq_masked, em);
      if (k == 3) check_fields(kind, ins);
    end
    mask_m = em;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    rst_n = 1'b0; i_ack = 1'b0; i_data = '0; flags = '0; irq = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_out(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(K_LDU, 16'hA35A, 16'h0000, 0);
    run(K_ALU, 16'h1712, 16'h0000, 0);
    run(K_JMP, 16'hF314, 16'h0001, 0);
    run(K_JMP, 16'hF314, 16'h0000, 0);
    run(K_ALU, 16'h1712, 16'h0000, 5);
    run(K_LDU, 16'hA35A, 16'h0000, 5);

    irq = 1'b1;
    run(K_NOP, 16'hFFFF, 16'h0000, 0);
    run(K_LDL, 16'hB2C3, 16'h0000, 2);
    run(K_RIT, 16'hFFF1, 16'h0000, 0);
    irq = 1'b0;
    run(K_RIT, 16'hFFF1, 16'h0000, 1);

    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(0, 8));
      irq  = ($urandom_range(0, 3) == 0);
      run(kind, gen(kind), 16'($urandom), int'($urandom_range(0, 3)));
    end

    irq = 1'b0;
    wait_req();
    i_ack  = 1'b1;
    i_data = 16'hFE00;
    @(negedge clk);
    i_ack  = 1'b0;
    chk("illegal_pc_inc", obs_strb(), 15'h0001);
    for (int k = 2; k <= 10; k++) begin
      // acks while halted must be ignored
      i_ack  = k[0];
      i_data = 16'hFFFF;
      @(negedge clk);
      chk($sformatf("halt_strobes k%0d", k), obs_strb(), 15'h0000);
      chk($sformatf("halt_i_req k%0d", k), i_req, 1'b0);
      chk($sformatf("halt_status k%0d", k), {halted, illegal}, 2'b11);
    end
    i_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_after_halt", all_out(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mask_m = 1'b0;
    @(negedge clk);
    run(K_LDL, 16'hB1A5, 16'h0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
